// File: rtl/ex_stage_if.sv
// Bus bundles around the execute stage: ID->EX issue, EX<->ALU operands/results, EX->MEM entry.
// The master modport belongs to the side that drives the forward payload.

interface id_ex_if #(parameter int unsigned DATA_WIDTH = 32);
  logic                  id_valid;
  logic                  id_ready;
  logic [DATA_WIDTH-1:0] id_pc;
  logic [5:0]            id_opcode;
  logic [5:0]            id_funct;
  logic [4:0]            id_shamt;
  logic [15:0]           id_imm;
  logic [DATA_WIDTH-1:0] id_rs_val;
  logic [DATA_WIDTH-1:0] id_rt_val;
  logic [4:0]            id_dest;
  logic                  flush;

  modport master (
    output id_valid, id_pc, id_opcode, id_funct, id_shamt, id_imm,
           id_rs_val, id_rt_val, id_dest, flush,
    input  id_ready
  );
  modport slave (
    input  id_valid, id_pc, id_opcode, id_funct, id_shamt, id_imm,
           id_rs_val, id_rt_val, id_dest, flush,
    output id_ready
  );
endinterface

interface alu_if #(parameter int unsigned DATA_WIDTH = 32);
  logic [DATA_WIDTH-1:0] alu_a;
  logic [DATA_WIDTH-1:0] alu_b;
  logic [2:0]            alu_op;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_zero;
  logic                  alu_ovf;

  modport master (output alu_a, alu_b, alu_op, input alu_result, alu_zero, alu_ovf);
  modport slave  (input alu_a, alu_b, alu_op, output alu_result, alu_zero, alu_ovf);
endinterface

interface ex_mem_if #(parameter int unsigned DATA_WIDTH = 32);
  logic                  ex_valid;
  logic                  mem_ready;
  logic [DATA_WIDTH-1:0] ex_result;
  logic [DATA_WIDTH-1:0] ex_store;
  logic [4:0]            ex_dest;
  logic                  ex_wen;
  logic                  ex_load;
  logic                  ex_storeen;
  logic                  ex_br_taken;
  logic [DATA_WIDTH-1:0] ex_br_target;
  logic [1:0]            ex_exc;

  modport master (
    output ex_valid, ex_result, ex_store, ex_dest, ex_wen, ex_load, ex_storeen,
           ex_br_taken, ex_br_target, ex_exc,
    input  mem_ready
  );
  modport slave (
    input  ex_valid, ex_result, ex_store, ex_dest, ex_wen, ex_load, ex_storeen,
           ex_br_taken, ex_br_target, ex_exc,
    output mem_ready
  );
endinterface

// File: rtl/ex_stage.sv
// MIPS execute stage: decodes the instruction, drives the external ALU and
// holds one EX/MEM entry behind a valid/ready handshake.

module ex_stage #(
  parameter int unsigned DATA_WIDTH = 32,  // only 32 is supported
  parameter bit          OVF_TRAP   = 1'b1
) (
  input  logic      clk,
  input  logic      resetn,
  id_ex_if.slave    id_bus,
  alu_if.master     alu_bus,
  ex_mem_if.master  mem_bus
);

  localparam int unsigned DW  = DATA_WIDTH;
  localparam int unsigned OPW = 3;

  localparam logic [OPW-1:0] OP_AND  = 3'b000;
  localparam logic [OPW-1:0] OP_OR   = 3'b001;
  localparam logic [OPW-1:0] OP_ADD  = 3'b010;
  localparam logic [OPW-1:0] OP_XOR  = 3'b011;
  localparam logic [OPW-1:0] OP_SRA  = 3'b100;
  localparam logic [OPW-1:0] OP_SLTU = 3'b101;
  localparam logic [OPW-1:0] OP_SUB  = 3'b110;
  localparam logic [OPW-1:0] OP_SLT  = 3'b111;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ADDIU = 6'h09;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_SLTIU = 6'h0B;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_XORI  = 6'h0E;
  localparam logic [5:0] OPC_LUI   = 6'h0F;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  logic [DW-1:0]  sext_c, zext_c, a_c, b_c, target_c;
  logic [OPW-1:0] op_c;
  logic           wen_c, load_c, storeen_c, br_c, bne_c, trap_c, illegal_c;
  logic           ovf_trap_c, taken_c, id_ready_c, capture_c;
  logic [1:0]     exc_c;

  logic          valid_q, valid_d;
  logic [DW-1:0] result_q, result_d, store_q, store_d, target_q, target_d;
  logic [4:0]    dest_q, dest_d;
  logic          wen_q, wen_d, load_q, load_d, storeen_q, storeen_d, taken_q, taken_d;
  logic [1:0]    exc_q, exc_d;

  assign sext_c = {{(DW-16){id_bus.id_imm[15]}}, id_bus.id_imm};
  assign zext_c = {{(DW-16){1'b0}}, id_bus.id_imm};

  // Instruction decode: operand selection, ALU opcode and writeback controls.
  always_comb begin
    a_c       = id_bus.id_rs_val;
    b_c       = id_bus.id_rt_val;
    op_c      = OP_AND;
    wen_c     = 1'b0;
    load_c    = 1'b0;
    storeen_c = 1'b0;
    br_c      = 1'b0;
    bne_c     = 1'b0;
    trap_c    = 1'b0;
    illegal_c = 1'b0;
    case (id_bus.id_opcode)
      OPC_RTYPE: begin
        wen_c = 1'b1;
        case (id_bus.id_funct)
          F_ADD:  begin op_c = OP_ADD; trap_c = 1'b1; end
          F_ADDU: op_c = OP_ADD;
          F_SUB:  begin op_c = OP_SUB; trap_c = 1'b1; end
          F_SUBU: op_c = OP_SUB;
          F_AND:  op_c = OP_AND;
          F_OR:   op_c = OP_OR;
          F_XOR:  op_c = OP_XOR;
          F_SLT:  op_c = OP_SLT;
          F_SLTU: op_c = OP_SLTU;
          F_SRA: begin
            a_c  = id_bus.id_rt_val;
            b_c  = DW'(id_bus.id_shamt);
            op_c = OP_SRA;
          end
          F_SRAV: begin
            a_c  = id_bus.id_rt_val;
            b_c  = DW'(id_bus.id_rs_val[4:0]);
            op_c = OP_SRA;
          end
          default: illegal_c = 1'b1;
        endcase
      end
      OPC_ADDI:  begin b_c = sext_c; op_c = OP_ADD;  wen_c = 1'b1; trap_c = 1'b1; end
      OPC_ADDIU: begin b_c = sext_c; op_c = OP_ADD;  wen_c = 1'b1; end
      OPC_LW:    begin b_c = sext_c; op_c = OP_ADD;  wen_c = 1'b1; load_c = 1'b1; end
      OPC_SW:    begin b_c = sext_c; op_c = OP_ADD;  storeen_c = 1'b1; end
      OPC_SLTI:  begin b_c = sext_c; op_c = OP_SLT;  wen_c = 1'b1; end
      OPC_SLTIU: begin b_c = sext_c; op_c = OP_SLTU; wen_c = 1'b1; end
      OPC_ANDI:  begin b_c = zext_c; op_c = OP_AND;  wen_c = 1'b1; end
      OPC_ORI:   begin b_c = zext_c; op_c = OP_OR;   wen_c = 1'b1; end
      OPC_XORI:  begin b_c = zext_c; op_c = OP_XOR;  wen_c = 1'b1; end
      OPC_LUI: begin
        a_c   = '0;
        b_c   = {id_bus.id_imm, {(DW-16){1'b0}}};
        op_c  = OP_OR;
        wen_c = 1'b1;
      end
      OPC_BEQ: begin op_c = OP_SUB; br_c = 1'b1; end
      OPC_BNE: begin op_c = OP_SUB; br_c = 1'b1; bne_c = 1'b1; end
      default: illegal_c = 1'b1;
    endcase
    // Illegal encodings present a quiet AND of zeros to the ALU.
    if (illegal_c) begin
      a_c       = '0;
      b_c       = '0;
      op_c      = OP_AND;
      wen_c     = 1'b0;
      trap_c    = 1'b0;
    end
  end

  assign alu_bus.alu_a  = a_c;
  assign alu_bus.alu_b  = b_c;
  assign alu_bus.alu_op = op_c;

  assign ovf_trap_c = OVF_TRAP & trap_c & alu_bus.alu_ovf;
  assign taken_c    = br_c & (bne_c ? ~alu_bus.alu_zero : alu_bus.alu_zero);
  assign exc_c      = illegal_c ? 2'b10 : (ovf_trap_c ? 2'b01 : 2'b00);
  assign target_c   = id_bus.id_pc + DW'(4) + (sext_c << 2);

  assign id_ready_c = ~valid_q | mem_bus.mem_ready;
  assign capture_c  = id_bus.id_valid & id_ready_c & ~id_bus.flush;
  assign id_bus.id_ready = id_ready_c;

  // Entry next-state: flush wins, then capture (which also covers consume-and-refill), then drain.
  always_comb begin
    valid_d   = valid_q;
    result_d  = result_q;
    store_d   = store_q;
    target_d  = target_q;
    dest_d    = dest_q;
    wen_d     = wen_q;
    load_d    = load_q;
    storeen_d = storeen_q;
    taken_d   = taken_q;
    exc_d     = exc_q;
    if (id_bus.flush || (!capture_c && mem_bus.mem_ready)) begin
      valid_d   = 1'b0;
      wen_d     = 1'b0;
      load_d    = 1'b0;
      storeen_d = 1'b0;
      taken_d   = 1'b0;
      exc_d     = 2'b00;
    end else if (capture_c) begin
      valid_d   = 1'b1;
      result_d  = alu_bus.alu_result;
      store_d   = id_bus.id_rt_val;
      target_d  = target_c;
      dest_d    = id_bus.id_dest;
      wen_d     = wen_c & ~ovf_trap_c;
      load_d    = load_c;
      storeen_d = storeen_c;
      taken_d   = taken_c;
      exc_d     = exc_c;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q   <= 1'b0;
      result_q  <= '0;
      store_q   <= '0;
      target_q  <= '0;
      dest_q    <= '0;
      wen_q     <= 1'b0;
      load_q    <= 1'b0;
      storeen_q <= 1'b0;
      taken_q   <= 1'b0;
      exc_q     <= 2'b00;
    end else begin
      valid_q   <= valid_d;
      result_q  <= result_d;
      store_q   <= store_d;
      target_q  <= target_d;
      dest_q    <= dest_d;
      wen_q     <= wen_d;
      load_q    <= load_d;
      storeen_q <= storeen_d;
      taken_q   <= taken_d;
      exc_q     <= exc_d;
    end
  end

  assign mem_bus.ex_valid     = valid_q;
  assign mem_bus.ex_result    = result_q;
  assign mem_bus.ex_store     = store_q;
  assign mem_bus.ex_br_target = target_q;
  assign mem_bus.ex_dest      = dest_q;
  assign mem_bus.ex_wen       = wen_q;
  assign mem_bus.ex_load      = load_q;
  assign mem_bus.ex_storeen   = storeen_q;
  assign mem_bus.ex_br_taken  = taken_q;
  assign mem_bus.ex_exc       = exc_q;

endmodule
